// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and register indices for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_RESUME} state_t;
  localparam int IFID = 0;
  localparam int IDEX = 1;
  localparam logic BUBBLE_V = 1'b0;
endpackage

// File: rtl/hazard_shadow.sv
// hazard_shadow: in-flight destination shift register with RAW comparators against the ID sources
module hazard_shadow
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int REGW = 5,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            CLR,
  input  logic            advance,
  input  logic            bubble,
  input  logic            id_wr_en,
  input  logic [REGW-1:0] id_wr_num,
  input  logic            id_rs_rd,
  input  logic [REGW-1:0] id_rs,
  input  logic            id_rt_rd,
  input  logic [REGW-1:0] id_rt,
  output logic            stall
);
  localparam int D = NSTAGE - 2;
  localparam int CHK = NSTAGE - 2 - WB_BYPASS;
  logic [D-1:0] v;
  logic [REGW-1:0] num [D];
  logic [D-1:0] hit;
  always_ff @(posedge clk)
    if (CLR) v <= '0;
    else if (advance) v <= {v[D-2:0], bubble ? BUBBLE_V : id_wr_en};
  always_ff @(posedge clk)
    if (advance) begin
      num[0] <= id_wr_num;
      for (int i = 1; i < D; i++) num[i] <= num[i-1];
    end
  for (genvar k = 0; k < D; k++) begin : g_cmp
    assign hit[k] = (k < CHK) && v[k] &&
                    ((id_rs_rd && |id_rs && (id_rs == num[k])) ||
                     (id_rt_rd && |id_rt && (id_rt == num[k])));
  end
  assign stall = |hit;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage enables/flushes for RAW stalls, branch flushes and SYSCALL halt/resume
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int REGW = 5,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              GO,
  input  logic              id_wr_en,
  input  logic [REGW-1:0]   id_wr_num,
  input  logic              id_rs_rd,
  input  logic              id_rt_rd,
  input  logic [REGW-1:0]   id_rs,
  input  logic [REGW-1:0]   id_rt,
  input  logic              ex_br_taken,
  input  logic              wb_halt,
  output logic              pc_en,
  output logic [NSTAGE-2:0] stage_en,
  output logic [NSTAGE-2:0] stage_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam int W = NSTAGE - 1;
  localparam logic [W-1:0] IFID_M = W'(1) << IFID;
  localparam logic [W-1:0] IDEX_M = W'(1) << IDEX;
  state_t state;
  logic go_q, stall, freeze, br, stl;
  assign freeze = (state == ST_HALT) || (state == ST_RUN && wb_halt);
  assign br = ~freeze & ex_br_taken;
  assign stl = ~freeze & ~ex_br_taken & stall;
  assign pc_en = ~freeze & ~stl;
  assign stage_en = freeze ? '0 : stl ? ~IFID_M : '1;
  assign stage_flush = br ? (IFID_M | IDEX_M) : stl ? IDEX_M : '0;
  hazard_shadow #(.NSTAGE(NSTAGE), .REGW(REGW), .WB_BYPASS(WB_BYPASS)) u_shadow (
    .clk(clk),
    .CLR(CLR),
    .advance(~freeze),
    .bubble(br | stl),
    .id_wr_en(id_wr_en),
    .id_wr_num(id_wr_num),
    .id_rs_rd(id_rs_rd),
    .id_rs(id_rs),
    .id_rt_rd(id_rt_rd),
    .id_rt(id_rt),
    .stall(stall)
  );
  always_ff @(posedge clk)
    if (CLR) begin
      state <= ST_RUN;
      go_q <= 1'b0;
      halted <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      go_q <= GO;
      cycle_cnt <= cycle_cnt + CNT_W'(~freeze & ~&cycle_cnt);
      stall_cnt <= stall_cnt + CNT_W'(stl & ~&stall_cnt);
      flush_cnt <= flush_cnt + CNT_W'(br & ~&flush_cnt);
      case (state)
        ST_RUN: if (wb_halt) begin
          state <= ST_HALT;
          halted <= 1'b1;
        end
        ST_HALT: if (GO & ~go_q) begin
          state <= ST_RESUME;
          halted <= 1'b0;
        end
        default: state <= ST_RUN;
      endcase
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a queue-of-writers reference model, default and no-bypass/4-bit-counter DUTs
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic CLR = 1'b1, GO = 1'b0, id_wr_en = 1'b0, id_rs_rd = 1'b0, id_rt_rd = 1'b0;
  logic ex_br_taken = 1'b0, wb_halt = 1'b0;
  logic [4:0] id_wr_num = '0, id_rs = '0, id_rt = '0;
  logic pc_en0, halted0, pc_en1, halted1;
  logic [3:0] en0, fl0, en1, fl1;
  logic [31:0] cyc0, stl0, fls0;
  logic [3:0] cyc1, stl1, fls1;
  always #5 clk = ~clk;
  pipe_hazard_ctrl dut0 (
    .clk(clk), .CLR(CLR), .GO(GO), .id_wr_en(id_wr_en), .id_wr_num(id_wr_num),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_rs(id_rs), .id_rt(id_rt),
    .ex_br_taken(ex_br_taken), .wb_halt(wb_halt), .pc_en(pc_en0), .stage_en(en0),
    .stage_flush(fl0), .halted(halted0), .cycle_cnt(cyc0), .stall_cnt(stl0), .flush_cnt(fls0)
  );
  pipe_hazard_ctrl #(.NSTAGE(5), .REGW(5), .WB_BYPASS(0), .CNT_W(4)) dut1 (
    .clk(clk), .CLR(CLR), .GO(GO), .id_wr_en(id_wr_en), .id_wr_num(id_wr_num),
    .id_rs_rd(id_rs_rd), .id_rt_rd(id_rt_rd), .id_rs(id_rs), .id_rt(id_rt),
    .ex_br_taken(ex_br_taken), .wb_halt(wb_halt), .pc_en(pc_en1), .stage_en(en1),
    .stage_flush(fl1), .halted(halted1), .cycle_cnt(cyc1), .stall_cnt(stl1), .flush_cnt(fls1)
  );
  typedef struct packed {
    logic pc;
    logic [3:0] en;
    logic [3:0] fl;
    logic hl;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fls;
  } exp_t;
  typedef struct {
    int inst;
    int num;
    int age;
  } wr_t;
  exp_t q0[$], q1[$];
  wr_t inflight[$];
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 1'b0;
  int m_st[2] = '{0, 0};
  bit m_goq[2] = '{1'b0, 1'b0};
  longint m_cyc[2] = '{0, 0}, m_stl[2] = '{0, 0}, m_fls[2] = '{0, 0};
  longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};
  int lim[2] = '{1, 2};
  task automatic cmp(input string nm, input int i, input longint a, input longint x);
    n_cmp++;
    if (a != x) begin
      n_bad++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, i, a, x, $time);
    end
  endtask
  task automatic compare(input int i, input exp_t x, input exp_t a);
    cmp("pc_en", i, longint'(a.pc), longint'(x.pc));
    cmp("stage_en", i, longint'(a.en), longint'(x.en));
    cmp("stage_flush", i, longint'(a.fl), longint'(x.fl));
    cmp("halted", i, longint'(a.hl), longint'(x.hl));
    cmp("cycle_cnt", i, longint'(a.cyc), longint'(x.cyc));
    cmp("stall_cnt", i, longint'(a.stl), longint'(x.stl));
    cmp("flush_cnt", i, longint'(a.fls), longint'(x.fls));
  endtask
  function automatic bit haz(int i, int src);
    foreach (inflight[j])
      if (inflight[j].inst == i && inflight[j].num == src && inflight[j].age <= lim[i]) return 1'b1;
    return 1'b0;
  endfunction
  task automatic step(input bit clr, input bit go, input bit we, input int wn, input bit rsr, input int rs,
                      input bit rtr, input int rt, input bit br, input bit wh);
    CLR = clr; GO = go; id_wr_en = we; id_wr_num = 5'(wn);
    id_rs_rd = rsr; id_rs = 5'(rs); id_rt_rd = rtr; id_rt = 5'(rt);
    ex_br_taken = br; wb_halt = wh;
    for (int i = 0; i < 2; i++) begin
      bit frz, hz, b, s;
      exp_t e;
      frz = (m_st[i] == 1) || (m_st[i] == 0 && wh);
      hz = (rsr && rs != 0 && haz(i, rs)) || (rtr && rt != 0 && haz(i, rt));
      b = !frz && br;
      s = !frz && !br && hz;
      e.pc = !frz && !s;
      e.en = frz ? 4'h0 : s ? 4'hE : 4'hF;
      e.fl = b ? 4'h3 : s ? 4'h2 : 4'h0;
      e.hl = (m_st[i] == 1);
      e.cyc = 32'(m_cyc[i]);
      e.stl = 32'(m_stl[i]);
      e.fls = 32'(m_fls[i]);
      if (chk_on) begin
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      if (clr) begin
        for (int j = inflight.size() - 1; j >= 0; j--) if (inflight[j].inst == i) inflight.delete(j);
        m_st[i] = 0; m_goq[i] = 1'b0; m_cyc[i] = 0; m_stl[i] = 0; m_fls[i] = 0;
      end else begin
        if (!frz) begin
          foreach (inflight[j]) if (inflight[j].inst == i) inflight[j].age++;
          for (int j = inflight.size() - 1; j >= 0; j--) if (inflight[j].age >= 3) inflight.delete(j);
          if (we && !(b || s)) inflight.push_back(wr_t'{inst: i, num: wn, age: 0});
        end
        if (!frz && m_cyc[i] < cmax[i]) m_cyc[i]++;
        if (s && m_stl[i] < cmax[i]) m_stl[i]++;
        if (b && m_fls[i] < cmax[i]) m_fls[i]++;
        if (m_st[i] == 0) m_st[i] = wh ? 1 : 0;
        else if (m_st[i] == 1) m_st[i] = (go && !m_goq[i]) ? 2 : 1;
        else m_st[i] = 0;
        m_goq[i] = go;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input bit go, input bit wh);
    step(1'b0, go, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, wh);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      compare(0, e, exp_t'({pc_en0, en0, fl0, halted0, cyc0, stl0, fls0}));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare(1, e, exp_t'({pc_en1, en1, fl1, halted1, 28'd0, cyc1, 28'd0, stl1, 28'd0, fls1}));
    end
  end
  initial begin
    bit gov;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    chk_on = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 8, 1'b0, 0, 1'b0, 1'b0);
    cmp("load_use_stalls", 0, longint'(stl0), 2);
    cmp("load_use_stalls", 1, longint'(stl1), 3);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    cmp("zero_reg_stalls", 0, longint'(stl0), 0);
    cmp("zero_reg_stalls", 1, longint'(stl1), 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 6, 1'b1, 5, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 6, 1'b0, 0, 1'b0, 1'b0);
    cmp("branch_flushes", 0, longint'(fls0), 1);
    cmp("branch_stalls", 0, longint'(stl0), 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    for (int n = 0; n < 3; n++) idle(1'b0, 1'b1);
    cmp("halt_cycles_frozen", 0, longint'(cyc0), 2);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    for (int n = 0; n < 3; n++) idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    cmp("resumed", 0, longint'(halted0), 0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    for (int n = 0; n < 3; n++) idle(1'b1, 1'b0);
    cmp("held_go_no_resume", 0, longint'(halted0), 1);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    cmp("reset_mid_halt_cycles", 0, longint'(cyc0), 0);
    cmp("reset_mid_halt_halted", 0, longint'(halted0), 0);
    idle(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) idle(1'b0, 1'b0);
    cmp("saturate_cycles", 1, longint'(cyc1), 15);
    cmp("free_cycles", 0, longint'(cyc0), 20);
    gov = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(4) == 0) gov = ~gov;
      step($urandom_range(96) == 0, gov, $urandom_range(1) == 1, int'($urandom_range(3)),
           $urandom_range(1) == 1, int'($urandom_range(3)), $urandom_range(1) == 1,
           int'($urandom_range(3)), $urandom_range(6) == 0, $urandom_range(19) == 0);
    end
    idle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    cmp("scoreboard_drained", 0, longint'(q0.size() + q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline control unit for the in-order MIPS core. It replaces the fixed global `!halt` enables of the five-stage top with per-stage enables and flushes. It tracks in-flight destination registers to detect RAW hazards, stalls ID on a hazard, flushes on a taken branch, and freezes or resumes the pipeline on SYSCALL halt and `GO`. It sits beside the control unit and drives every inter-stage register plus the PC.

## Interface
- `NSTAGE`, default 5: pipeline depth (≥4); inter-stage registers are indexed 0..NSTAGE-2 (0 = IF/ID).
- `REGW`, default 5: register-number width.
- `WB_BYPASS`, default 1: 1 = register file writes before reads, so the WB-stage destination is excluded from hazard checks.
- `CNT_W`, default 32: width of the statistics counters.
- `clk` in 1: clock.
- `CLR` in 1: synchronous, active-high reset.
- `GO` in 1: resume request; level input, edge-detected internally.
- `id_wr_en` in 1: instruction in ID writes a GPR.
- `id_wr_num` in REGW: its destination register.
- `id_rs_rd`, `id_rt_rd` in 1: ID reads rs / rt.
- `id_rs`, `id_rt` in REGW: source register numbers.
- `ex_br_taken` in 1: branch or jump in EX is taken.
- `wb_halt` in 1: halting SYSCALL is in WB.
- `pc_en` out 1: PC load enable.
- `stage_en` out NSTAGE-1: inter-stage register enables.
- `stage_flush` out NSTAGE-1: load a bubble (NOP, all signals 0) instead of data.
- `halted` out 1: pipeline frozen.
- `cycle_cnt`, `stall_cnt`, `flush_cnt` out CNT_W: statistics.

## Operation
- State machine with three states:
  - RUN → HALT when `wb_halt`.
  - HALT → RESUME on `GO` rising edge (`GO & ~go_q`).
  - RESUME → RUN unconditionally.
  - `CLR` → RUN from any state.
- Shadow: NSTAGE-2 entries `{v, num}`, one per stage EX..WB, entry 0 = EX. The shadow shifts whenever the pipeline advances. Entry 0 loads `{id_wr_en & ~bubble, id_wr_num}`, where bubble = stall or flush into ID/EX.
- Hazard (`stall`): `id_rs_rd & id_rs != 0` (or the rt equivalent) matches a valid entry k, for k in 0..NSTAGE-3-WB_BYPASS. Register $0 never hazards.
- Priority, highest first:
  1. **Halt**: RUN & `wb_halt`, or HALT. All `stage_en` = 0, `pc_en` = 0, flush = 0, shadow holds.
  2. **Branch**: `ex_br_taken`. `pc_en` = 1, all enables 1, `stage_flush[0]` and `stage_flush[1]` = 1. Any simultaneous stall is discarded and not counted.
  3. **Stall**: `pc_en` = 0, `stage_en[0]` = 0 (IF/ID holds), `stage_flush[1]` = 1, registers 1..NSTAGE-2 enabled.
  4. **Normal**: all enables 1, flush 0.
- In RESUME, `wb_halt` is ignored so the halting instruction can retire.
- Counters saturate at all-ones:
  - `cycle_cnt` +1 in every cycle not frozen.
  - `stall_cnt` +1 per counted stall cycle.
  - `flush_cnt` +1 per branch flush.
- `halted` is registered: 1 exactly while state = HALT.

## Timing
- Enables and flushes are combinational from the current state, shadow and inputs, with zero latency. All state updates occur on the `clk` rising edge.
- `halted` rises one cycle after the first `wb_halt` cycle. Enables drop in that same first cycle.
- `GO` held high for many cycles produces exactly one resume. A further halt requires a new `GO` edge.
- After `CLR`:
  - state RUN, shadow invalid, counters 0, `go_q` 0, `halted` 0.
  - Hence `pc_en` = 1, `stage_en` all 1, `stage_flush` all 0.
- `CLR` asserted mid-stall, mid-halt or mid-RESUME still yields exactly the reset state above.
- `GO` edge in the same cycle as `CLR`: the resume is discarded.

## Structure
- `pipe_ctrl_pkg` contains:
  - state enum (`ST_RUN`, `ST_HALT`, `ST_RESUME`)
  - inter-stage register index constants (`IFID`, `IDEX`)
  - the bubble encoding constant
- Sub-module `hazard_shadow` holds the destination shift register and comparators and outputs `stall`. Parameters are NSTAGE, REGW and WB_BYPASS; inputs are the advance and bubble strobes.

## Test plan
- **Load-use stall (defaults)**: ID writes $8, then the next ID reads rs=8 → `stall` for exactly 2 cycles (`pc_en` = 0, `stage_flush[1]` = 1), `stall_cnt` = 2. With WB_BYPASS=0 the same sequence gives 3 stall cycles.
- **$0 source**: writer to $0 followed by a reader of rt=0 → no stall, `stall_cnt` = 0.
- **Branch overrides stall**: stall pending and `ex_br_taken` = 1 → `stage_flush` = 2'b11 on registers 0 and 1, `pc_en` = 1, `flush_cnt` = 1, `stall_cnt` unchanged, shadow entry 0 invalid next cycle.
- **Halt and resume**: `wb_halt` = 1 → `stage_en` = 0 the same cycle, `halted` = 1 next, `cycle_cnt` frozen. `GO` held for 5 cycles → one RESUME cycle with `wb_halt` ignored, then RUN, `halted` = 0.
- **Reset mid-halt**: `CLR` pulse while HALT with counters nonzero → next cycle RUN, all counters 0, enables all 1.
- **Counter saturation**: with CNT_W=4, run 20 cycles → `cycle_cnt` stays at 15.
